// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC fine-time encoder: default geometry,
// FSM state encoding and an elaboration-time clog2 helper.
package tdc_pkg;

    localparam int NCARRY4_DEF  = 32'sd8;
    localparam int NTAPS_DEF    = 32'sd4 * NCARRY4_DEF;
    localparam int COARSE_W_DEF = 32'sd16;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_LOW = 1'b1
    } tdc_state_t;

    // Smallest r with 2**r >= value; used to size counts that must reach NTAPS.
    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 32'sd1;
            end
        end
        return r;
    endfunction

    localparam int FINE_W_DEF = clog2(NTAPS_DEF + 32'sd1);

endpackage

// File: rtl/tdc_fine_encoder_if.sv
// Timestamp output channel: valid/ready handshake carrying fine code,
// coarse count and saturation flag.
interface tdc_fine_encoder_if
    import tdc_pkg::*;
#(
    parameter int COARSE_W = COARSE_W_DEF,
    parameter int FINE_W   = FINE_W_DEF
);

    logic                hit_valid;
    logic                hit_ready;
    logic [FINE_W-1:0]   hit_fine;
    logic [COARSE_W-1:0] hit_coarse;
    logic                hit_sat;

    modport master (
        output hit_valid,
        output hit_fine,
        output hit_coarse,
        output hit_sat,
        input  hit_ready
    );

    modport slave (
        input  hit_valid,
        input  hit_fine,
        input  hit_coarse,
        input  hit_sat,
        output hit_ready
    );

endinterface

// File: rtl/tdc_popcount.sv
// Combinational population count of the sampled tap vector as a balanced
// pairwise adder tree; bubbles in the thermometer code are simply counted.
module tdc_popcount
    import tdc_pkg::*;
#(
    parameter int NTAPS  = NTAPS_DEF,
    parameter int FINE_W = clog2(NTAPS + 32'sd1)
) (
    input  logic [NTAPS-1:0]  i_taps,
    output logic [FINE_W-1:0] o_count
);

    localparam int LEVELS = clog2(NTAPS);
    localparam int LEAVES = 32'sd1 <<< LEVELS;

    // Leaves padded with zeros up to a power of two, then summed level by level.
    always_comb begin
        logic [FINE_W-1:0] tree [0:LEVELS][0:LEAVES-1];
        for (int lv = 32'sd0; lv <= LEVELS; lv++) begin
            for (int k = 32'sd0; k < LEAVES; k++) begin
                tree[lv][k] = {FINE_W{1'b0}};
            end
        end
        for (int k = 32'sd0; k < NTAPS; k++) begin
            tree[0][k] = FINE_W'(i_taps[k]);
        end
        for (int lv = 32'sd1; lv <= LEVELS; lv++) begin
            for (int k = 32'sd0; k < (LEAVES >>> lv); k++) begin
                tree[lv][k] = tree[lv-1][2*k] + tree[lv-1][2*k+1];
            end
        end
        o_count = tree[LEVELS][0];
    end

endmodule

// File: rtl/tdc_fine_encoder.sv
// TDC fine-time encoder: double-samples the delay-line taps, detects the
// rising edge of tap 0 and emits a fine/coarse timestamp over a handshake.
module tdc_fine_encoder
    import tdc_pkg::*;
#(
    parameter int NCARRY4  = NCARRY4_DEF,
    parameter int NTAPS    = 32'sd4 * NCARRY4,
    parameter int COARSE_W = COARSE_W_DEF,
    parameter int FINE_W   = clog2(NTAPS + 32'sd1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NTAPS-1:0]     taps,
    input  logic                 enable,
    tdc_fine_encoder_if.master   hit_if,
    output logic                 overflow
);

    logic [NTAPS-1:0]    r_s1;
    logic [NTAPS-1:0]    r_s2;
    logic [COARSE_W-1:0] r_coarse;
    tdc_state_t          r_state;
    logic                r_hit_valid;
    logic [FINE_W-1:0]   r_hit_fine;
    logic [COARSE_W-1:0] r_hit_coarse;
    logic                r_hit_sat;
    logic                r_overflow;

    logic [FINE_W-1:0]   w_popcnt;
    logic                w_hit;
    logic                w_xfer;

    tdc_popcount #(
        .NTAPS  (NTAPS),
        .FINE_W (FINE_W)
    ) u_popcount (
        .i_taps  (r_s2),
        .o_count (w_popcnt)
    );

    // Only the first sample with tap 0 set counts; WAIT_LOW masks the rest of the pulse.
    assign w_hit  = (r_state == ST_IDLE) && enable && r_s2[0];
    assign w_xfer = r_hit_valid && hit_if.hit_ready;

    // Two-flop capture of the asynchronous taps and the free-running coarse count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1     <= {NTAPS{1'b0}};
            r_s2     <= {NTAPS{1'b0}};
            r_coarse <= {COARSE_W{1'b0}};
        end else begin
            r_s1     <= taps;
            r_s2     <= r_s1;
            r_coarse <= r_coarse + COARSE_W'(1'b1);
        end
    end

    // Edge-detect FSM together with the registered timestamp and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_hit_valid  <= 1'b0;
            r_hit_fine   <= {FINE_W{1'b0}};
            r_hit_coarse <= {COARSE_W{1'b0}};
            r_hit_sat    <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        r_state <= ST_WAIT_LOW;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!r_s2[0]) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT_LOW;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // A hit may replace the payload only when the slot is empty or draining now.
            if (w_hit && (!r_hit_valid || hit_if.hit_ready)) begin
                r_hit_valid  <= 1'b1;
                r_hit_fine   <= w_popcnt;
                r_hit_coarse <= r_coarse;
                r_hit_sat    <= (w_popcnt == FINE_W'(NTAPS));
            end else if (w_hit) begin
                r_overflow   <= 1'b1;
            end else if (w_xfer) begin
                r_hit_valid  <= 1'b0;
            end else begin
                r_hit_valid  <= r_hit_valid;
            end
        end
    end

    assign hit_if.hit_valid  = r_hit_valid;
    assign hit_if.hit_fine   = r_hit_fine;
    assign hit_if.hit_coarse = r_hit_coarse;
    assign hit_if.hit_sat    = r_hit_sat;
    assign overflow          = r_overflow;

endmodule

// File: tb/tb_tdc_fine_encoder.sv
// Directed bench for tdc_fine_encoder: stimulus pushes hand-computed
// timestamps into a queue, a negedge monitor pops them on each transfer.
module tb_tdc_fine_encoder;

    typedef struct packed {
        logic [5:0]  fine;
        logic [15:0] coarse;
        logic        sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] taps;
    logic        enable;
    logic        overflow;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          tb_cyc;
    exp_t        q[$];

    tdc_fine_encoder_if #(.COARSE_W(16), .FINE_W(6)) hif ();

    tdc_fine_encoder #(
        .NCARRY4  (8),
        .COARSE_W (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .taps     (taps),
        .enable   (enable),
        .hit_if   (hif),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Bench-side edge count since reset release (edge 1 is the first one).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [5:0] f, input logic [15:0] c, input logic s);
        exp_t e;
        e.fine   = f;
        e.coarse = c;
        e.sat    = s;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"},    {31'd0, hif.hit_valid}, 32'd0);
        chk({tag, "_fine"},     {26'd0, hif.hit_fine},  32'd0);
        chk({tag, "_coarse"},   {16'd0, hif.hit_coarse}, 32'd0);
        chk({tag, "_sat"},      {31'd0, hif.hit_sat},   32'd0);
        chk({tag, "_overflow"}, {31'd0, overflow},      32'd0);
    endtask

    // Scoreboard monitor: every accepted timestamp must match the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && hif.hit_valid === 1'b1 && hif.hit_ready === 1'b1) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_hit: got fine=%0d coarse=%0d sat=%0d with empty queue",
                         hif.hit_fine, hif.hit_coarse, hif.hit_sat);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (hif.hit_fine !== e.fine || hif.hit_coarse !== e.coarse || hif.hit_sat !== e.sat) begin
                    n_fail++;
                    $display("FAIL hit_payload: got fine=%0d coarse=%0d sat=%0d expected fine=%0d coarse=%0d sat=%0d",
                             hif.hit_fine, hif.hit_coarse, hif.hit_sat, e.fine, e.coarse, e.sat);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        taps          = 32'h0;
        enable        = 1'b0;
        hif.hit_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");

        // First hit: taps settle before edge 5 -> timestamp after edge 7, coarse 6.
        rst_n         = 1'b1;
        enable        = 1'b1;
        hif.hit_ready = 1'b1;
        tick(4);
        taps = 32'h0000_00FF;
        push(6'd8, 16'd6, 1'b0);
        tick(2);
        chk("valid_before_edge7", {31'd0, hif.hit_valid}, 32'd0);
        tick(1);
        chk("valid_after_edge7", {31'd0, hif.hit_valid}, 32'd1);
        chk("first_fine", {26'd0, hif.hit_fine}, 32'd8);
        chk("first_coarse", {16'd0, hif.hit_coarse}, 32'd6);
        tick(1);
        chk("valid_pulse_end", {31'd0, hif.hit_valid}, 32'd0);
        tick(8);

        // One low cycle re-arms; bubble code counts 7 set taps.
        taps = 32'h0;
        tick(1);
        taps = 32'h0000_00F7;
        push(6'd7, 16'(tb_cyc + 2), 1'b0);
        tick(6);
        taps = 32'h0;
        tick(4);

        taps = 32'hFFFF_FFFF;
        push(6'd32, 16'(tb_cyc + 2), 1'b1);
        tick(5);
        taps = 32'h0;
        tick(4);

        // Backpressure: second hit dropped, overflow sticks.
        hif.hit_ready = 1'b0;
        taps = 32'h0000_0003;
        push(6'd2, 16'(tb_cyc + 2), 1'b0);
        tick(4);
        taps = 32'h0;
        tick(3);
        chk("overflow_still_clear", {31'd0, overflow}, 32'd0);
        taps = 32'h0000_001F;
        tick(4);
        chk("overflow_set", {31'd0, overflow}, 32'd1);
        chk("held_valid", {31'd0, hif.hit_valid}, 32'd1);
        chk("held_fine", {26'd0, hif.hit_fine}, 32'd2);
        taps = 32'h0;
        hif.hit_ready = 1'b1;
        tick(1);
        chk("drained_valid", {31'd0, hif.hit_valid}, 32'd0);
        chk("overflow_sticky", {31'd0, overflow}, 32'd1);
        tick(3);

        // New hit loaded on the same edge as the pending transfer.
        hif.hit_ready = 1'b0;
        taps = 32'h0000_0001;
        push(6'd1, 16'(tb_cyc + 2), 1'b0);
        tick(4);
        taps = 32'h0;
        tick(3);
        taps = 32'h0000_0007;
        push(6'd3, 16'(tb_cyc + 2), 1'b0);
        tick(2);
        hif.hit_ready = 1'b1;
        tick(1);
        chk("coincident_valid", {31'd0, hif.hit_valid}, 32'd1);
        chk("coincident_fine", {26'd0, hif.hit_fine}, 32'd3);
        chk("coincident_overflow", {31'd0, overflow}, 32'd1);
        taps = 32'h0;
        tick(4);

        // Enable low blocks detection entirely.
        enable = 1'b0;
        taps = 32'h0000_00FF;
        tick(6);
        chk("enable_low_no_hit", {31'd0, hif.hit_valid}, 32'd0);
        taps = 32'h0;
        tick(4);
        enable = 1'b1;
        tick(2);

        // Coarse wrap: taps before edge 65535 -> coarse 65536 mod 2^16 = 0.
        while (tb_cyc < 65534) tick(1);
        taps = 32'h0000_00FF;
        push(6'd8, 16'd0, 1'b0);
        tick(4);
        taps = 32'h0;
        tick(4);

        // Asynchronous reset with a pending timestamp.
        hif.hit_ready = 1'b0;
        taps = 32'h0000_003F;
        tick(4);
        chk("pending_valid", {31'd0, hif.hit_valid}, 32'd1);
        chk("pending_fine", {26'd0, hif.hit_fine}, 32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        taps = 32'h0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        chk("post_reset_valid", {31'd0, hif.hit_valid}, 32'd0);
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
